// File: rtl/mod_counter.sv
// Up/down modulo counter with prescaler, wrap/saturate modes,
// terminal-count pulse and sticky wrap flag.
module mod_counter #(
    parameter int N   = 8,
    parameter int PRE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic         up,
    input  logic         sat,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] max_val,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         ovf
);

    localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRE - 1);

    logic [PW-1:0] ps;
    logic          step;
    logic          term;
    logic [N-1:0]  nxt;

    always_comb begin
        step = en && (ps == PS_LAST);
        term = up ? (count >= max_val) : (count == '0);
        nxt  = count;
        if (up) begin
            if (term) nxt = sat ? max_val : '0;
            else      nxt = count + N'(1);
        end else begin
            // a count above the bound (e.g. after load) snaps down to it
            if (term)                 nxt = sat ? '0 : max_val;
            else if (count > max_val) nxt = max_val;
            else                      nxt = count - N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            ps    <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            ps    <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            ps    <= '0;
            tc    <= 1'b0;
        end else if (en) begin
            if (step) begin
                ps    <= '0;
                count <= nxt;
                tc    <= term;
                if (term && !sat) ovf <= 1'b1;
            end else begin
                ps <= ps + PW'(1);
                tc <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (PRE=1 and PRE=4).
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset, en, clr, load, up, sat;
    logic [7:0] load_val, max_val;
    logic [7:0] count, count4;
    logic       tc, ovf, tc4, ovf4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mod_counter #(.N(8), .PRE(1)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
        .up(up), .sat(sat), .load_val(load_val), .max_val(max_val),
        .count(count), .tc(tc), .ovf(ovf)
    );

    mod_counter #(.N(8), .PRE(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
        .up(up), .sat(sat), .load_val(load_val), .max_val(max_val),
        .count(count4), .tc(tc4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b0; clr = 1'b0; load = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        up = 1'b1; sat = 1'b0; load_val = 8'd0; max_val = 8'd9;
        #2;

        // reset state
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_tc", tc, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_count4", count4, 0);

        // up, wrap, max 9
        max_val = 8'd9; up = 1'b1; sat = 1'b0; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("upw_count_%0d", k), count, k % 10);
            chk($sformatf("upw_tc_%0d", k), tc, (k == 10));
            chk($sformatf("upw_ovf_%0d", k), ovf, (k >= 10));
        end

        // up, saturate, max 9
        do_reset();
        max_val = 8'd9; up = 1'b1; sat = 1'b1; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("ups_count_%0d", k), count, (k < 9) ? k : 9);
            chk($sformatf("ups_tc_%0d", k), tc, (k >= 10));
            chk($sformatf("ups_ovf_%0d", k), ovf, 0);
        end

        // down, wrap, max 5
        do_reset();
        max_val = 8'd5; up = 1'b0; sat = 1'b0; en = 1'b1;
        begin
            logic [7:0] dseq [7];
            dseq = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd5};
            for (int k = 0; k < 7; k++) begin
                tick();
                chk($sformatf("dnw_count_%0d", k), count, dseq[k]);
                chk($sformatf("dnw_tc_%0d", k), tc, (k == 0 || k == 6));
                chk($sformatf("dnw_ovf_%0d", k), ovf, 1);
            end
        end
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_ovf", ovf, 0);
        chk("clr_tc", tc, 0);

        // down, saturate at 0 holds with tc
        en = 1'b1; sat = 1'b1;
        tick();
        chk("dns_count", count, 0);
        chk("dns_tc", tc, 1);
        chk("dns_ovf", ovf, 0);
        en = 1'b0;
        tick();
        chk("dns_tc_idle", tc, 0);

        // prescaler 4 with en gap
        do_reset();
        max_val = 8'd255; up = 1'b1; sat = 1'b0;
        en = 1'b1; tick(); tick();
        chk("pre_ph2", count4, 0);
        en = 1'b0; tick(); tick(); tick();
        chk("pre_hold", count4, 0);
        chk("pre_hold_tc", tc4, 0);
        en = 1'b1; tick();
        chk("pre_en3", count4, 0);
        tick();
        chk("pre_en4", count4, 1);
        tick(); tick(); tick();
        chk("pre_en7", count4, 1);
        tick();
        chk("pre_en8", count4, 2);
        chk("pre_ovf", ovf4, 0);

        // load above bound
        do_reset();
        max_val = 8'd100; load_val = 8'd200; up = 1'b1; sat = 1'b0;
        load = 1'b1; tick(); load = 1'b0;
        chk("ld_count", count, 200);
        en = 1'b1; tick(); en = 1'b0;
        chk("ldup_count", count, 0);
        chk("ldup_tc", tc, 1);
        chk("ldup_ovf", ovf, 1);
        load = 1'b1; en = 1'b1; tick(); load = 1'b0;
        chk("ldre_count", count, 200);
        chk("ldre_tc", tc, 0);
        chk("ldre_ovf", ovf, 1);
        up = 1'b0; tick(); en = 1'b0;
        chk("lddn_count", count, 100);
        chk("lddn_tc", tc, 0);

        // max_val 0 wraps every step
        do_reset();
        max_val = 8'd0; up = 1'b1; sat = 1'b0; en = 1'b1;
        tick();
        chk("m0_count", count, 0);
        chk("m0_tc", tc, 1);
        chk("m0_ovf", ovf, 1);
        up = 1'b0; tick(); en = 1'b0;
        chk("m0dn_count", count, 0);
        chk("m0dn_tc", tc, 1);

        // priority
        load_val = 8'd50; max_val = 8'd255; load = 1'b1; tick();
        chk("pr_pre", count, 50);
        reset = 1'b1; clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'd77;
        tick();
        reset = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
        chk("pr_rst_count", count, 0);
        chk("pr_rst_ovf", ovf, 0);
        chk("pr_rst_tc", tc, 0);
        load = 1'b1; tick();
        chk("pr_ld77", count, 77);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("pr_clrld", count, 0);
        up = 1'b1; load_val = 8'd33; en = 1'b1; tick();
        load = 1'b0; en = 1'b0;
        chk("pr_lden_count", count, 33);
        chk("pr_lden_tc", tc, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
